// File: rtl/spike_router_mp.sv
// spike_router_mp: multi-port spike router. Each source port has its own spike FIFO.
// A round-robin arbiter selects one pending spike. Its fanout is then walked through a
// single-port connection table, and every valid entry is emitted as a tagged event.
// Optional build macro: ROUTER_DROP_STATS_EN adds per-port 16-bit saturating drop
// counters, which are readable in region 0x12.
module spike_router_mp #(
    parameter int NUM_PORTS   = 4,
    parameter int NUM_NEURONS = 256,
    parameter int ID_W        = 8,
    parameter int MAX_FANOUT  = 32,
    parameter int FANOUT_W    = 5,
    parameter int WEIGHT_W    = 8,
    parameter int DELAY_W     = 4,
    parameter int FIFO_DEPTH  = 16,
    localparam int PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_PORTS-1:0]      s_spike_valid,
    input  logic [NUM_PORTS*ID_W-1:0] s_spike_id,
    output logic [NUM_PORTS-1:0]      s_spike_ready,
    output logic                      m_valid,
    output logic [ID_W-1:0]           m_dest_id,
    output logic [WEIGHT_W-1:0]       m_weight,
    output logic                      m_exc_inh,
    output logic [DELAY_W-1:0]        m_delay,
    output logic [PORT_W-1:0]         m_src_port,
    input  logic                      m_ready,
    input  logic                      cfg_we,
    input  logic                      cfg_re,
    input  logic [31:0]               cfg_addr,
    input  logic [31:0]               cfg_wdata,
    output logic [31:0]               cfg_rdata,
    output logic                      cfg_rvalid,
    output logic [31:0]               routed_count,
    output logic [NUM_PORTS-1:0]      overflow,
    output logic                      busy
);
    localparam int CONN_W    = 2 + WEIGHT_W + DELAY_W + ID_W;
    localparam int NID_W     = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int TBL_AW    = NID_W + FANOUT_W;
    localparam int TBL_DEPTH = NUM_NEURONS * MAX_FANOUT;
    localparam int FPTR_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W     = FANOUT_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_POP, S_READ, S_WAIT, S_EVAL, S_EMIT, S_NEXT} state_t;

    logic [CONN_W-1:0] tbl_mem [TBL_DEPTH];
    logic [CONN_W-1:0] tbl_rdata_q;
    logic [ID_W-1:0]   fifo_mem [NUM_PORTS][FIFO_DEPTH];

    state_t              state_q, state_d;
    logic [FPTR_W-1:0]   fifo_wr_q [NUM_PORTS], fifo_wr_d [NUM_PORTS];
    logic [FPTR_W-1:0]   fifo_rd_q [NUM_PORTS], fifo_rd_d [NUM_PORTS];
    logic [CNT_W-1:0]    count_q [NUM_NEURONS], count_d [NUM_NEURONS];
    logic [PORT_W-1:0]   ptr_q, ptr_d, grant_q, grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, idx_q, idx_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [CONN_W-1:0]   entry_q, entry_d;
    logic                m_valid_q, m_valid_d, m_exc_q, m_exc_d;
    logic [ID_W-1:0]     m_dest_q, m_dest_d;
    logic [WEIGHT_W-1:0] m_weight_q, m_weight_d;
    logic [DELAY_W-1:0]  m_delay_q, m_delay_d;
    logic [PORT_W-1:0]   m_port_q, m_port_d;
    logic [31:0]         routed_q, routed_d, cfg_rdata_q, cfg_rdata_d;
    logic                cfg_rvalid_q, cfg_rvalid_d, cfg_rd_tbl_q, cfg_rd_tbl_d;
    logic [NUM_PORTS-1:0] overflow_q, overflow_d;

    logic [NUM_PORTS-1:0] fifo_empty, fifo_full, fifo_push, fifo_pop, drop_evt;
    logic                 arb_found, emit_hs;
    logic [PORT_W-1:0]    arb_sel, cand;
    logic [ID_W-1:0]      pop_id;
    logic [CNT_W-1:0]     pop_cnt;
    logic [7:0]           region;
    logic                 tbl_idx_ok, cnt_idx_ok, tbl_we, cfg_tbl_rd, clr_cnt, clr_ovf;
    logic [TBL_AW-1:0]    tbl_raddr;
    logic [15:0]          drop_rd;
    logic                 unused_bits;

    assign region      = cfg_addr[31:24];
    assign tbl_idx_ok  = {16'd0, cfg_addr[15:0]} < 32'(TBL_DEPTH);
    assign cnt_idx_ok  = {16'd0, cfg_addr[15:0]} < 32'(NUM_NEURONS);
    assign tbl_we      = cfg_we && (region == 8'h00) && tbl_idx_ok;
    assign cfg_tbl_rd  = cfg_re && (region == 8'h00) && tbl_idx_ok;
    assign clr_cnt     = cfg_we && (region == 8'h02) && cfg_wdata[0];
    assign clr_ovf     = cfg_we && (region == 8'h02) && cfg_wdata[1];
    assign tbl_raddr   = cfg_tbl_rd ? cfg_addr[TBL_AW-1:0] : {id_q[NID_W-1:0], idx_q[FANOUT_W-1:0]};
    assign pop_id      = fifo_mem[grant_q][fifo_rd_q[grant_q][FPTR_W-2:0]];
    assign pop_cnt     = ({{(32-ID_W){1'b0}}, pop_id} < 32'(NUM_NEURONS)) ? count_q[pop_id[NID_W-1:0]] : '0;
    assign unused_bits = ^{cfg_addr[23:16], cfg_wdata};

    // FIFO status, push/overflow detection and pointer advance per port
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            fifo_empty[p] = (fifo_wr_q[p] == fifo_rd_q[p]);
            fifo_full[p]  = (fifo_wr_q[p][FPTR_W-1] != fifo_rd_q[p][FPTR_W-1]) &&
                            (fifo_wr_q[p][FPTR_W-2:0] == fifo_rd_q[p][FPTR_W-2:0]);
            fifo_push[p]  = s_spike_valid[p] && !fifo_full[p];
            drop_evt[p]   = s_spike_valid[p] && fifo_full[p];
            fifo_wr_d[p]  = fifo_wr_q[p] + FPTR_W'(fifo_push[p]);
            fifo_rd_d[p]  = fifo_rd_q[p] + FPTR_W'(fifo_pop[p]);
        end
    end

    // round-robin search for the first non-empty port starting at the pointer
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = '0;
        cand      = ptr_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!arb_found && !fifo_empty[cand]) begin
                arb_found = 1'b1;
                arb_sel   = cand;
            end
            cand = (cand == PORT_W'(NUM_PORTS - 1)) ? '0 : cand + 1'b1;
        end
    end

    // traversal FSM: next state, traversal registers and output event registers
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        id_d       = id_q;
        entry_d    = entry_q;
        m_valid_d  = m_valid_q;
        m_dest_d   = m_dest_q;
        m_weight_d = m_weight_q;
        m_exc_d    = m_exc_q;
        m_delay_d  = m_delay_q;
        m_port_d   = m_port_q;
        fifo_pop   = '0;
        emit_hs    = 1'b0;
        case (state_q)
            S_IDLE: if (arb_found) begin
                grant_d = arb_sel;
                state_d = S_POP;
            end
            S_POP: begin
                fifo_pop[grant_q] = 1'b1;
                id_d    = pop_id;
                ptr_d   = (grant_q == PORT_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
                cnt_d   = (pop_cnt > CNT_W'(MAX_FANOUT)) ? CNT_W'(MAX_FANOUT) : pop_cnt;
                idx_d   = '0;
                state_d = (pop_cnt == '0) ? S_IDLE : S_READ;
            end
            // a table read from the config side owns the BRAM port this cycle
            S_READ: if (!cfg_tbl_rd) state_d = S_WAIT;
            S_WAIT: begin
                entry_d = tbl_rdata_q;
                state_d = S_EVAL;
            end
            S_EVAL: if (entry_q[CONN_W-1]) begin
                m_valid_d  = 1'b1;
                m_exc_d    = entry_q[CONN_W-2];
                m_weight_d = entry_q[CONN_W-3 -: WEIGHT_W];
                m_delay_d  = entry_q[ID_W +: DELAY_W];
                m_dest_d   = entry_q[ID_W-1:0];
                m_port_d   = grant_q;
                state_d    = S_EMIT;
            end else begin
                state_d = S_NEXT;
            end
            S_EMIT: if (m_ready) begin
                m_valid_d = 1'b0;
                emit_hs   = 1'b1;
                state_d   = S_NEXT;
            end
            S_NEXT: begin
                idx_d   = idx_q + 1'b1;
                state_d = ((idx_q + 1'b1) == cnt_q) ? S_IDLE : S_READ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // statistics, count-table writes and registered config reads; clears win over increments
    always_comb begin
        routed_d   = clr_cnt ? 32'd0 : routed_q + 32'(emit_hs);
        overflow_d = clr_ovf ? '0 : (overflow_q | drop_evt);
        count_d    = count_q;
        if (cfg_we && (region == 8'h01) && cnt_idx_ok)
            count_d[cfg_addr[NID_W-1:0]] = cfg_wdata[FANOUT_W:0];
        cfg_rvalid_d = cfg_re;
        cfg_rd_tbl_d = 1'b0;
        cfg_rdata_d  = cfg_rd_tbl_q ? 32'(tbl_rdata_q) : cfg_rdata_q;
        if (cfg_re) begin
            case (region)
                8'h00: begin
                    cfg_rdata_d  = 32'd0;
                    cfg_rd_tbl_d = tbl_idx_ok;
                end
                8'h01: cfg_rdata_d = cnt_idx_ok ? 32'(count_q[cfg_addr[NID_W-1:0]]) : 32'd0;
                8'h10: cfg_rdata_d = routed_q;
                8'h11: cfg_rdata_d = 32'(overflow_q);
                8'h12: cfg_rdata_d = 32'(drop_rd);
                default: cfg_rdata_d = 32'hDEADBEEF;
            endcase
        end
    end

`ifdef ROUTER_DROP_STATS_EN
    logic [15:0] drop_q [NUM_PORTS], drop_d [NUM_PORTS];

    // saturating per-port drop counters and read-port selection
    always_comb begin
        drop_rd = 16'd0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            drop_d[p] = drop_q[p];
            if (clr_cnt) drop_d[p] = 16'd0;
            else if (drop_evt[p] && (drop_q[p] != 16'hFFFF)) drop_d[p] = drop_q[p] + 16'd1;
            if (cfg_addr[2:0] == 3'(p)) drop_rd = drop_q[p];
        end
    end

    // drop counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) drop_q <= '{default: '0};
        else        drop_q <= drop_d;
    end
`else
    assign drop_rd = 16'd0;
`endif

    // control and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            fifo_wr_q    <= '{default: '0};
            fifo_rd_q    <= '{default: '0};
            count_q      <= '{default: '0};
            ptr_q        <= '0;
            grant_q      <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            m_valid_q    <= 1'b0;
            m_dest_q     <= '0;
            m_weight_q   <= '0;
            m_exc_q      <= 1'b0;
            m_delay_q    <= '0;
            m_port_q     <= '0;
            routed_q     <= 32'd0;
            overflow_q   <= '0;
            cfg_rdata_q  <= 32'd0;
            cfg_rvalid_q <= 1'b0;
            cfg_rd_tbl_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_rd_q    <= fifo_rd_d;
            count_q      <= count_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            m_valid_q    <= m_valid_d;
            m_dest_q     <= m_dest_d;
            m_weight_q   <= m_weight_d;
            m_exc_q      <= m_exc_d;
            m_delay_q    <= m_delay_d;
            m_port_q     <= m_port_d;
            routed_q     <= routed_d;
            overflow_q   <= overflow_d;
            cfg_rdata_q  <= cfg_rdata_d;
            cfg_rvalid_q <= cfg_rvalid_d;
            cfg_rd_tbl_q <= cfg_rd_tbl_d;
        end
    end

    // datapath registers that never need a reset value
    always_ff @(posedge clk) begin
        id_q    <= id_d;
        entry_q <= entry_d;
    end

    // connection table: synchronous single-port read, config-side write
    always_ff @(posedge clk) begin
        if (tbl_we) tbl_mem[cfg_addr[TBL_AW-1:0]] <= cfg_wdata[CONN_W-1:0];
        tbl_rdata_q <= tbl_mem[tbl_raddr];
    end

    // spike FIFO storage
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++)
            if (fifo_push[p]) fifo_mem[p][fifo_wr_q[p][FPTR_W-2:0]] <= s_spike_id[p*ID_W +: ID_W];
    end

    assign s_spike_ready = ~fifo_full;
    assign m_valid       = m_valid_q;
    assign m_dest_id     = m_dest_q;
    assign m_weight      = m_weight_q;
    assign m_exc_inh     = m_exc_q;
    assign m_delay       = m_delay_q;
    assign m_src_port    = m_port_q;
    assign cfg_rdata     = cfg_rd_tbl_q ? 32'(tbl_rdata_q) : cfg_rdata_q;
    assign cfg_rvalid    = cfg_rvalid_q;
    assign routed_count  = routed_q;
    assign overflow      = overflow_q;
    assign busy          = (state_q != S_IDLE) || !(&fifo_empty);
endmodule

// File: tb/tb_spike_router_mp.sv
// Directed testbench for spike_router_mp (default parameters).
module tb_spike_router_mp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  s_spike_valid = '0;
    logic [31:0] s_spike_id = '0;
    logic [3:0]  s_spike_ready;
    logic        m_valid;
    logic [7:0]  m_dest_id;
    logic [7:0]  m_weight;
    logic        m_exc_inh;
    logic [3:0]  m_delay;
    logic [1:0]  m_src_port;
    logic        m_ready = 1'b0;
    logic        cfg_we = 1'b0;
    logic        cfg_re = 1'b0;
    logic [31:0] cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata;
    logic        cfg_rvalid;
    logic [31:0] routed_count;
    logic [3:0]  overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spike_router_mp dut (
        .clk(clk), .rst_n(rst_n),
        .s_spike_valid(s_spike_valid), .s_spike_id(s_spike_id), .s_spike_ready(s_spike_ready),
        .m_valid(m_valid), .m_dest_id(m_dest_id), .m_weight(m_weight), .m_exc_inh(m_exc_inh),
        .m_delay(m_delay), .m_src_port(m_src_port), .m_ready(m_ready),
        .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid),
        .routed_count(routed_count), .overflow(overflow), .busy(busy)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_entry(input int v, input int exc, input int w, input int dly, input int dest);
        logic [21:0] e;
        e = {v[0], exc[0], w[7:0], dly[3:0], dest[7:0]};
        return 32'(e);
    endfunction

    task automatic cfg_write(input logic [7:0] region, input logic [15:0] idx, input logic [31:0] data);
        cfg_we = 1'b1; cfg_addr = {region, 8'h00, idx}; cfg_wdata = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic [7:0] region, input logic [15:0] idx, output logic [31:0] data, output logic rv);
        cfg_re = 1'b1; cfg_addr = {region, 8'h00, idx};
        tick();
        cfg_re = 1'b0;
        data = cfg_rdata;
        rv = cfg_rvalid;
    endtask

    task automatic spike(input logic [3:0] ports, input logic [31:0] ids);
        s_spike_valid = ports; s_spike_id = ids;
        tick();
        s_spike_valid = '0;
    endtask

    task automatic take_event(input string tag, input int dest, input int w, input int exc, input int dly, input int port);
        int n;
        logic [22:0] exp_evt;
        n = 0;
        while (m_valid !== 1'b1 && n < 200) begin tick(); n++; end
        chk({tag, "_vld"}, 64'(m_valid), 64'(1));
        exp_evt = {dest[7:0], w[7:0], exc[0], dly[3:0], port[1:0]};
        chk({tag, "_evt"}, 64'({m_dest_id, m_weight, m_exc_inh, m_delay, m_src_port}), 64'(exp_evt));
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk({tag, "_drop"}, 64'(m_valid), 64'(0));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 500) begin tick(); n++; end
        chk({tag, "_idle"}, 64'(busy), 64'(0));
    endtask

    initial begin
        logic [31:0] rd;
        logic rv;
        int writes, evs, exp_drop;
        logic stable;
        int order_a [4];
        int order_c [4];

        // reset
        rst_n = 1'b0;
        tick(); tick();
        chk("rst_mvalid", 64'(m_valid), 64'(0));
        chk("rst_mdata", 64'({m_dest_id, m_weight, m_exc_inh, m_delay, m_src_port}), 64'(0));
        chk("rst_routed", 64'(routed_count), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        chk("rst_cfg", 64'({cfg_rvalid, cfg_rdata}), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ready", 64'(s_spike_ready), 64'(4'hF));
        rst_n = 1'b1;
        tick();

        // configuration
        cfg_write(8'h01, 16'd5, 32'd3);
        cfg_write(8'h01, 16'd6, 32'd1);
        cfg_write(8'h01, 16'd7, 32'd2);
        for (int p = 0; p < 4; p++) cfg_write(8'h01, 16'(20 + p), 32'd1);
        cfg_write(8'h00, 16'd160, mk_entry(1, 1, 8'h40, 2, 9));
        cfg_write(8'h00, 16'd161, mk_entry(0, 1, 8'h55, 1, 3));
        cfg_write(8'h00, 16'd162, mk_entry(1, 0, 8'h10, 5, 200));
        cfg_write(8'h00, 16'd192, mk_entry(1, 1, 8'h01, 0, 1));
        cfg_write(8'h00, 16'd224, mk_entry(1, 1, 8'h22, 3, 11));
        cfg_write(8'h00, 16'd225, mk_entry(1, 0, 8'h33, 1, 12));
        for (int p = 0; p < 4; p++)
            cfg_write(8'h00, 16'((20 + p) * 32), mk_entry(1, 1, 8'h50 + p, p, 100 + p));

        cfg_read(8'h00, 16'd162, rd, rv);
        chk("rd_entry", 64'({rv, rd}), 64'({1'b1, 32'h002105C8}));
        cfg_read(8'h01, 16'd5, rd, rv);
        chk("rd_count", 64'(rd), 64'(3));
        cfg_read(8'h05, 16'd0, rd, rv);
        chk("rd_bad_region", 64'(rd), 64'(32'hDEADBEEF));
        cfg_read(8'h10, 16'd0, rd, rv);
        chk("rd_routed0", 64'(rd), 64'(0));
        tick();
        chk("rvalid_pulse", 64'(cfg_rvalid), 64'(0));

        // single spike, neuron 5: two events with one invalid entry skipped
        spike(4'b0001, 32'h0000_0005);
        tick(); tick(); tick(); tick();
        chk("lat_early", 64'(m_valid), 64'(0));
        tick();
        chk("lat_first", 64'(m_valid), 64'(1));
        take_event("n5_e0", 9, 8'h40, 1, 2, 0);
        take_event("n5_e1", 200, 8'h10, 0, 5, 0);
        wait_idle("n5");
        chk("n5_routed", 64'(routed_count), 64'(2));

        // backpressure: hold m_ready low 10 cycles on first event of neuron 7
        spike(4'b0001, 32'h0000_0007);
        for (int n = 0; n < 50 && m_valid !== 1'b1; n++) tick();
        stable = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if ({m_valid, m_dest_id, m_weight, m_exc_inh, m_delay, m_src_port} !==
                {1'b1, 8'd11, 8'h22, 1'b1, 4'd3, 2'd0}) stable = 1'b0;
            tick();
        end
        chk("hold_stable", 64'(stable), 64'(1));
        take_event("n7_e0", 11, 8'h22, 1, 3, 0);
        take_event("n7_e1", 12, 8'h33, 0, 1, 0);
        wait_idle("n7");
        chk("n7_routed", 64'(routed_count), 64'(4));

        // count=0 neuron: back to IDLE within 2 cycles, nothing emitted
        spike(4'b0001, 32'h0000_0008);
        tick(); tick();
        chk("zero_busy", 64'(busy), 64'(0));
        chk("zero_mvalid", 64'(m_valid), 64'(0));
        chk("zero_routed", 64'(routed_count), 64'(4));

        // FIFO overflow on port 1 while the FSM is stalled in EMIT
        spike(4'b0001, 32'h0000_0005);
        for (int n = 0; n < 50 && m_valid !== 1'b1; n++) tick();
        writes = 0;
        s_spike_valid = 4'b0010; s_spike_id = 32'h0000_0600;
        for (int n = 0; n < 20; n++) begin
            if (s_spike_ready[1]) writes++;
            tick();
        end
        s_spike_valid = '0;
        chk("ovf_writes", 64'(writes), 64'(16));
        chk("ovf_ready", 64'(s_spike_ready), 64'(4'b1101));
        chk("ovf_flag", 64'(overflow), 64'(4'b0010));
        cfg_read(8'h12, 16'd1, rd, rv);
`ifdef ROUTER_DROP_STATS_EN
        exp_drop = 4;
`else
        exp_drop = 0;
`endif
        chk("drop_cnt", 64'(rd), 64'(exp_drop));
        m_ready = 1'b1;
        evs = 0;
        for (int n = 0; n < 3000; n++) begin
            if (m_valid) evs++;
            if (!busy && !m_valid) break;
            tick();
        end
        m_ready = 1'b0;
        chk("drain_events", 64'(evs), 64'(18));
        chk("drain_routed", 64'(routed_count), 64'(22));

        // clear in the same cycle as an emit handshake: clear wins
        spike(4'b0100, 32'h0006_0000);
        for (int n = 0; n < 50 && m_valid !== 1'b1; n++) tick();
        chk("clr_pre_vld", 64'(m_valid), 64'(1));
        m_ready = 1'b1; cfg_we = 1'b1; cfg_addr = 32'h0200_0000; cfg_wdata = 32'd3;
        tick();
        m_ready = 1'b0; cfg_we = 1'b0;
        chk("clr_routed", 64'(routed_count), 64'(0));
        chk("clr_ovf", 64'(overflow), 64'(0));
        chk("clr_mvalid", 64'(m_valid), 64'(0));
        wait_idle("clr");

        // burst on all ports resumes after last grant (port 2): order 3,0,1,2
        order_a = '{3, 0, 1, 2};
        spike(4'b1111, 32'h1716_1514);
        for (int k = 0; k < 4; k++)
            take_event($sformatf("burstA%0d", k), 100 + order_a[k], 8'h50 + order_a[k], 1, order_a[k], order_a[k]);
        wait_idle("burstA");
        chk("burstA_routed", 64'(routed_count), 64'(4));

        // reset while in EMIT
        spike(4'b0001, 32'h0000_0005);
        for (int n = 0; n < 50 && m_valid !== 1'b1; n++) tick();
        chk("emit_before_rst", 64'(m_valid), 64'(1));
        rst_n = 1'b0;
        tick();
        chk("rst_emit_mvalid", 64'(m_valid), 64'(0));
        chk("rst_emit_busy", 64'(busy), 64'(0));
        chk("rst_emit_routed", 64'(routed_count), 64'(0));
        rst_n = 1'b1;
        tick();
        cfg_read(8'h00, 16'd160, rd, rv);
        chk("tbl_kept", 64'({rv, rd}), 64'({1'b1, mk_entry(1, 1, 8'h40, 2, 9)}));
        cfg_read(8'h01, 16'd5, rd, rv);
        chk("count_cleared", 64'(rd), 64'(0));

        // after reset the pointer starts at port 0
        for (int p = 0; p < 4; p++) cfg_write(8'h01, 16'(20 + p), 32'd1);
        spike(4'b1111, 32'h1716_1514);
        for (int k = 0; k < 4; k++)
            take_event($sformatf("burstB%0d", k), 100 + k, 8'h50 + k, 1, k, k);
        wait_idle("burstB");
        spike(4'b0010, 32'h0000_1500);
        take_event("single_p1", 101, 8'h51, 1, 1, 1);
        wait_idle("single");
        order_c = '{2, 3, 0, 1};
        spike(4'b1111, 32'h1716_1514);
        for (int k = 0; k < 4; k++)
            take_event($sformatf("burstC%0d", k), 100 + order_c[k], 8'h50 + order_c[k], 1, order_c[k], order_c[k]);
        wait_idle("burstC");
        cfg_read(8'h10, 16'd0, rd, rv);
        chk("final_routed", 64'({rv, rd}), 64'({1'b1, 32'd9}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
